// File: rtl/inference_sequencer.sv
// Run controller: walks image_num through the test-image ROM, starts the network,
// takes a sequential signed argmax of its scores and hands the label out over valid/ready.
// Define INFERENCE_ACCURACY_EN to add expected_label / correct_count accuracy counting.
module inference_sequencer #(
  parameter int unsigned NUM_IMAGES  = 10000,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned SCORE_WIDTH = 16,
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned CONTINUOUS  = 0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 abort,
  output logic [$clog2(NUM_IMAGES)-1:0]        image_num,
  output logic                                 inputs_ready,
  input  logic                                 outputs_ready,
  input  logic [NUM_CLASSES*SCORE_WIDTH-1:0]   scores,
  output logic [$clog2(NUM_CLASSES)-1:0]       label,
  output logic                                 label_valid,
  input  logic                                 label_ready,
`ifdef INFERENCE_ACCURACY_EN
  input  logic [$clog2(NUM_CLASSES)-1:0]       expected_label,
  output logic [$clog2(NUM_IMAGES+1)-1:0]      correct_count,
`endif
  output logic                                 busy,
  output logic                                 done
);

  localparam int unsigned IMG_W     = $clog2(NUM_IMAGES);
  localparam int unsigned LBL_W     = $clog2(NUM_CLASSES);
  localparam int unsigned FETCH_CYC = (ROM_LATENCY == 0) ? 1 : ROM_LATENCY;

  localparam logic [IMG_W-1:0] LAST_IMG   = IMG_W'(NUM_IMAGES - 1);
  localparam logic [LBL_W-1:0] LAST_K     = LBL_W'(NUM_CLASSES - 1);
  localparam logic [2:0]       FETCH_LAST = 3'(FETCH_CYC - 1);

  typedef enum logic [2:0] {IDLE, FETCH, RUN, ARGMAX, OUTPUT} state_e;

  state_e                               state_q, state_d;
  logic [IMG_W-1:0]                     image_num_q, image_num_d;
  logic [2:0]                           fetch_cnt_q, fetch_cnt_d;
  // Class 0 seeds best directly at capture, so only classes 1..N-1 are stored.
  logic [(NUM_CLASSES-1)*SCORE_WIDTH-1:0] scores_q, scores_d;
  logic signed [SCORE_WIDTH-1:0]        best_q, best_d;
  logic [LBL_W-1:0]                     idx_q, idx_d;
  logic [LBL_W-1:0]                     k_q, k_d;
  logic [LBL_W-1:0]                     label_q, label_d;
  logic                                 inputs_ready_q, inputs_ready_d;
  logic                                 label_valid_q, label_valid_d;
  logic                                 busy_q, busy_d;
  logic                                 done_q, done_d;

  logic [LBL_W-1:0]                     km1;
  logic signed [SCORE_WIDTH-1:0]        cand;
  logic                                 cand_gt;
  logic                                 last_img;

  always_comb begin
    state_d        = state_q;
    image_num_d    = image_num_q;
    fetch_cnt_d    = fetch_cnt_q;
    scores_d       = scores_q;
    best_d         = best_q;
    idx_d          = idx_q;
    k_d            = k_q;
    label_d        = label_q;
    inputs_ready_d = 1'b0;
    label_valid_d  = label_valid_q;
    done_d         = done_q;

    km1      = k_q - LBL_W'(1);
    cand     = scores_q[int'(km1)*SCORE_WIDTH +: SCORE_WIDTH];
    cand_gt  = cand > best_q;
    last_img = (image_num_q == LAST_IMG);

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d     = FETCH;
          image_num_d = '0;
          fetch_cnt_d = '0;
          done_d      = 1'b0;
        end
      end
      FETCH: begin
        if (fetch_cnt_q == FETCH_LAST) begin
          state_d        = RUN;
          inputs_ready_d = 1'b1;
        end else begin
          fetch_cnt_d = fetch_cnt_q + 3'd1;
        end
      end
      RUN: begin
        if (outputs_ready) begin
          scores_d = scores[NUM_CLASSES*SCORE_WIDTH-1:SCORE_WIDTH];
          best_d   = scores[SCORE_WIDTH-1:0];
          idx_d    = '0;
          k_d      = LBL_W'(1);
          state_d  = ARGMAX;
        end
      end
      ARGMAX: begin
        if (cand_gt) begin
          best_d = cand;
          idx_d  = k_q;
        end
        if (k_q == LAST_K) begin
          label_d       = cand_gt ? k_q : idx_q;
          label_valid_d = 1'b1;
          state_d       = OUTPUT;
        end else begin
          k_d = k_q + LBL_W'(1);
        end
      end
      OUTPUT: begin
        if (label_ready) begin
          label_valid_d = 1'b0;
          fetch_cnt_d   = '0;
          if (!last_img) begin
            image_num_d = image_num_q + IMG_W'(1);
            state_d     = FETCH;
          end else if (CONTINUOUS == 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (enable) begin
            image_num_d = '0;
            state_d     = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d        = IDLE;
      label_valid_d  = 1'b0;
      done_d         = 1'b0;
      inputs_ready_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      image_num_q    <= '0;
      fetch_cnt_q    <= '0;
      scores_q       <= '0;
      best_q         <= '0;
      idx_q          <= '0;
      k_q            <= '0;
      label_q        <= '0;
      inputs_ready_q <= 1'b0;
      label_valid_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      image_num_q    <= image_num_d;
      fetch_cnt_q    <= fetch_cnt_d;
      scores_q       <= scores_d;
      best_q         <= best_d;
      idx_q          <= idx_d;
      k_q            <= k_d;
      label_q        <= label_d;
      inputs_ready_q <= inputs_ready_d;
      label_valid_q  <= label_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

`ifdef INFERENCE_ACCURACY_EN
  localparam int unsigned CNT_W = $clog2(NUM_IMAGES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_IMAGES);

  logic [CNT_W-1:0] correct_count_q, correct_count_d;

  // state_d already folds in abort, so an aborted handshake never counts.
  always_comb begin
    correct_count_d = correct_count_q;
    if (state_q == IDLE && state_d == FETCH) begin
      correct_count_d = '0;
    end else if (state_q == OUTPUT && state_d == FETCH && last_img) begin
      correct_count_d = '0;
    end else if (state_q == OUTPUT && label_ready && !abort &&
                 label_q == expected_label && correct_count_q != MAX_CNT) begin
      correct_count_d = correct_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) correct_count_q <= '0;
    else        correct_count_q <= correct_count_d;
  end

  assign correct_count = correct_count_q;
`endif

  assign image_num    = image_num_q;
  assign inputs_ready = inputs_ready_q;
  assign label        = label_q;
  assign label_valid  = label_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench: single-pass controller (3 images, 10 classes, ROM latency 2)
// and continuous controller (3 images, 4 classes, ROM latency 0).
module tb_inference_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic         en1, ab1, ordy1, lrdy1;
  logic [159:0] sc1;
  logic [1:0]   img1;
  logic         ir1;
  logic [3:0]   lab1;
  logic         lv1, busy1, done1;

  logic         en2, ab2, ordy2, lrdy2;
  logic [31:0]  sc2;
  logic [1:0]   img2;
  logic         ir2;
  logic [1:0]   lab2;
  logic         lv2, busy2, done2;

`ifdef INFERENCE_ACCURACY_EN
  logic [3:0] exp1;
  logic [1:0] cc1;
  logic [1:0] exp2;
  logic [1:0] cc2;
`endif

  inference_sequencer #(
    .NUM_IMAGES(3), .NUM_CLASSES(10), .SCORE_WIDTH(16), .ROM_LATENCY(2), .CONTINUOUS(0)
  ) dut1 (
    .clock(clock), .reset(reset), .enable(en1), .abort(ab1),
    .image_num(img1), .inputs_ready(ir1), .outputs_ready(ordy1), .scores(sc1),
    .label(lab1), .label_valid(lv1), .label_ready(lrdy1),
`ifdef INFERENCE_ACCURACY_EN
    .expected_label(exp1), .correct_count(cc1),
`endif
    .busy(busy1), .done(done1)
  );

  inference_sequencer #(
    .NUM_IMAGES(3), .NUM_CLASSES(4), .SCORE_WIDTH(8), .ROM_LATENCY(0), .CONTINUOUS(1)
  ) dut2 (
    .clock(clock), .reset(reset), .enable(en2), .abort(ab2),
    .image_num(img2), .inputs_ready(ir2), .outputs_ready(ordy2), .scores(sc2),
    .label(lab2), .label_valid(lv2), .label_ready(lrdy2),
`ifdef INFERENCE_ACCURACY_EN
    .expected_label(exp2), .correct_count(cc2),
`endif
    .busy(busy2), .done(done2)
  );

  int checks = 0;
  int errors = 0;
  int pulses1 = 0;
  int cyc = 0;
  int ir2_img[$];
  int ir2_cyc[$];
  int s1[10];
  int n;
  int exp_seq[5] = '{0, 1, 2, 0, 1};

  always @(negedge clock) begin
    cyc++;
    if (ir1) pulses1++;
    if (ir2) begin
      ir2_img.push_back(int'(img2));
      ir2_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ir1(output int cnt);
    cnt = 0;
    do begin tick(); cnt++; end while (!ir1 && cnt < 50);
  endtask

  task automatic wait_lv1(output int cnt);
    cnt = 0;
    do begin tick(); cnt++; end while (!lv1 && cnt < 50);
  endtask

  task automatic load1();
    for (int i = 0; i < 10; i++) sc1[i*16 +: 16] = 16'(s1[i]);
  endtask

  initial begin
    reset = 1'b0;
    en1 = 0; ab1 = 0; ordy1 = 0; lrdy1 = 0; sc1 = '0;
    en2 = 0; ab2 = 0; ordy2 = 0; lrdy2 = 0; sc2 = '0;
`ifdef INFERENCE_ACCURACY_EN
    exp1 = '0; exp2 = 2'd1;
`endif
    repeat (2) tick();
    check("rst_img", img1, 0);
    check("rst_ir", ir1, 0);
    check("rst_label", lab1, 0);
    check("rst_lv", lv1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    reset = 1'b1;
    tick();
    check("idle_busy", busy1, 0);

    // image 0: tie between classes 2 and 3
    s1 = '{3, -1, 7, 7, 0, 0, 0, 0, 0, 0}; load1();
`ifdef INFERENCE_ACCURACY_EN
    exp1 = 4'd2;
`endif
    en1 = 1; tick(); en1 = 0;
    check("start_busy", busy1, 1);
    check("start_img", img1, 0);
    wait_ir1(n);
    check("fetch_cycles", n, 2);
    tick();
    check("ir_one_cycle", ir1, 0);
    ordy1 = 1; n = 0;
    do begin tick(); n++; ordy1 = 0; end while (!lv1 && n < 50);
    check("latency", n, 10);
    check("tie_label", lab1, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_lv", lv1, 1);
      check("hold_label", lab1, 2);
      check("hold_img", img1, 0);
    end
    check("hold_no_ir", pulses1, 1);
    lrdy1 = 1; tick(); lrdy1 = 0;
    check("hs_img", img1, 1);
    check("hs_lv", lv1, 0);

    // image 1: all negative, maximum -2 at class 9
    s1 = '{-5, -3, -100, -7, -32768, -9, -4, -3, -6, -2}; load1();
`ifdef INFERENCE_ACCURACY_EN
    exp1 = 4'd9;
`endif
    wait_ir1(n);
    check("fetch_cycles2", n, 2);
    ordy1 = 1; tick(); ordy1 = 0;
    wait_lv1(n);
    check("neg_label", lab1, 9);
    lrdy1 = 1; tick(); lrdy1 = 0;
    check("img_two", img1, 2);

    // image 2: signed max 100 at class 0, unsigned max would be -1 at class 1
    s1 = '{100, -1, -32768, 50, 0, 99, -50, 100, 7, 3}; load1();
`ifdef INFERENCE_ACCURACY_EN
    exp1 = 4'd5;
`endif
    wait_ir1(n);
    repeat (2) tick();
    ordy1 = 1; tick(); ordy1 = 0;
    wait_lv1(n);
    check("signed_label", lab1, 0);
    lrdy1 = 1; tick(); lrdy1 = 0;
    check("end_done", done1, 1);
    check("end_busy", busy1, 0);
    check("end_lv", lv1, 0);
    check("end_pulses", pulses1, 3);
`ifdef INFERENCE_ACCURACY_EN
    check("acc_count", cc1, 2);
`endif

    // restart, then abort during RUN of image 1
    s1 = '{3, -1, 7, 7, 0, 0, 0, 0, 0, 0}; load1();
    en1 = 1; tick(); en1 = 0;
    check("restart_done", done1, 0);
    check("restart_img", img1, 0);
`ifdef INFERENCE_ACCURACY_EN
    check("acc_clear", cc1, 0);
`endif
    wait_ir1(n);
    ordy1 = 1; tick(); ordy1 = 0;
    wait_lv1(n);
    lrdy1 = 1; tick(); lrdy1 = 0;
    wait_ir1(n);
    ab1 = 1; tick(); ab1 = 0;
    check("abort_busy", busy1, 0);
    check("abort_img", img1, 1);
    check("abort_label", lab1, 2);
    check("abort_lv", lv1, 0);
    ordy1 = 1; repeat (3) tick(); ordy1 = 0;
    check("late_result_lv", lv1, 0);
    check("late_result_busy", busy1, 0);
    en1 = 1; tick(); en1 = 0;
    check("reenable_img", img1, 0);

    // asynchronous reset in the middle of ARGMAX on image 1
    wait_ir1(n);
    ordy1 = 1; tick(); ordy1 = 0;
    wait_lv1(n);
    lrdy1 = 1; tick(); lrdy1 = 0;
    wait_ir1(n);
    ordy1 = 1; tick(); ordy1 = 0;
    repeat (3) tick();
    check("pre_reset_img", img1, 1);
    reset = 1'b0;
    #1;
    check("arst_img", img1, 0);
    check("arst_label", lab1, 0);
    check("arst_busy", busy1, 0);
    check("arst_lv", lv1, 0);
    check("arst_ir", ir1, 0);
    tick();
    reset = 1'b1;
    tick();

    // continuous controller: wrap 2 -> 0 while enable is high
    sc2 = {8'sd2, 8'sd5, 8'sd5, 8'sd1};
    ir2_img.delete();
    ir2_cyc.delete();
    en2 = 1; ordy2 = 1; lrdy2 = 1;
    n = 0;
    do begin tick(); n++; end while (ir2_img.size() < 5 && n < 200);
    en2 = 0;
    check("cont_pulses", ir2_img.size(), 5);
    for (int i = 0; i < 5; i++) check("cont_img_seq", ir2_img[i], exp_seq[i]);
    check("cont_period", ir2_cyc[1] - ir2_cyc[0], 6);
    check("cont_wrap_period", ir2_cyc[3] - ir2_cyc[2], 6);
    check("cont_label", lab2, 1);
    n = 0;
    do begin tick(); n++; end while (busy2 && n < 200);
    check("cont_stop_busy", busy2, 0);
    check("cont_stop_done", done2, 0);
    check("cont_stop_img", img2, 2);
    check("cont_total_pulses", ir2_img.size(), 6);
`ifdef INFERENCE_ACCURACY_EN
    check("cont_acc_count", cc2, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inference_sequencer.md
Name: inference_sequencer

Overview:
- Top-level run controller for the dense-network classifier.
- Steps an image index through the test-image ROM and starts the neural network for each image.
- Runs a sequential signed argmax over the network's output scores and presents each label over a valid/ready handshake.
- Successor to the fixed single-shot controller: generalises class count, score width, ROM latency and run mode, and adds backpressure, abort and optional accuracy counting.

Parameters:
- NUM_IMAGES, 10000: images per pass; image_num runs 0..NUM_IMAGES-1.
- NUM_CLASSES, 10: network output count; must be >= 2.
- SCORE_WIDTH, 16: signed two's-complement width of each score (INTEGER_WIDTH+FRACTION_WIDTH).
- ROM_LATENCY, 1: cycles from image_num change to valid image data; range 0..7.
- CONTINUOUS, 0: 0 = one pass, then stop; 1 = wrap image_num to 0 and keep running while enable is high.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  start request; sampled in IDLE; in CONTINUOUS mode, also sampled at each wrap.
- abort  in  1  synchronous abort, returns to IDLE.
- image_num  out  $clog2(NUM_IMAGES)  ROM address of the current image.
- inputs_ready  out  1  one-cycle start pulse to the network.
- outputs_ready  in  1  network results valid; sampled only in RUN.
- scores  in  NUM_CLASSES*SCORE_WIDTH  flattened signed scores; class i occupies bits [i*SCORE_WIDTH +: SCORE_WIDTH].
- label  out  $clog2(NUM_CLASSES)  argmax class index.
- label_valid  out  1  label available.
- label_ready  in  1  consumer accepts label.
- busy  out  1  high in every state except IDLE.
- done  out  1  high in IDLE after a completed non-continuous pass; cleared on the next start.

Behaviour:
- Reset (reset=0): state=IDLE, image_num=0, label=0, label_valid=0, inputs_ready=0, busy=0, done=0, internal counters=0.
- States: IDLE, FETCH, RUN, ARGMAX, OUTPUT.
- IDLE:
  - enable=1 -> FETCH; image_num=0, done=0.
- FETCH:
  - Waits ROM_LATENCY cycles, then -> RUN.
  - With ROM_LATENCY=0, FETCH lasts exactly 1 cycle.
- RUN:
  - inputs_ready pulses high on the first RUN cycle only.
  - Waits for outputs_ready=1; on that cycle, all scores are captured into an internal register.
  - -> ARGMAX.
  - outputs_ready in any other state is ignored.
- ARGMAX:
  - best=score[0], idx=0 at entry.
  - Each cycle compares class k (k=1..NUM_CLASSES-1); a strictly greater signed score replaces best/idx.
  - Ties keep the lowest index.
  - Takes NUM_CLASSES-1 cycles, then loads label=idx -> OUTPUT.
- OUTPUT:
  - label_valid=1; label is held stable until label_ready=1.
  - On handshake:
    - image_num < NUM_IMAGES-1: image_num+1 -> FETCH.
    - Last image with CONTINUOUS=0: -> IDLE, done=1.
    - Last image with CONTINUOUS=1 and enable=1: image_num=0 -> FETCH.
    - Last image with CONTINUOUS=1 and enable=0: -> IDLE, done=0.
- Latency, outputs_ready to label_valid rising: NUM_CLASSES cycles (capture + NUM_CLASSES-1 compares).
- abort=1 in any state -> IDLE next cycle:
  - label_valid=0, done=0.
  - image_num and label hold their values.
  - An in-flight network result is discarded.
  - abort has priority over all other transitions.
- Asynchronous reset mid-operation forces all reset values immediately.

Optional Feature:
- Macro: INFERENCE_ACCURACY_EN.
- Enabled:
  - Adds input expected_label [$clog2(NUM_CLASSES)], valid while image_num is stable.
  - Adds output correct_count [$clog2(NUM_IMAGES+1)], reset to 0 and cleared when IDLE->FETCH.
  - correct_count increments by 1 at each OUTPUT handshake where label==expected_label.
  - correct_count saturates at NUM_IMAGES.
  - In CONTINUOUS mode, correct_count clears at each wrap.
- Disabled: neither port exists and no counter logic is built.

Test Plan:
- Scores {3,-1,7,7,0,...}, NUM_CLASSES=10 -> label=2 (first of the tied maxima); label_valid rises 10 cycles after outputs_ready.
- All scores negative, max -2 at class 9 -> label=9 (signed compare, no unsigned wrap).
- label_ready held low 5 cycles in OUTPUT -> label stable, image_num unchanged, no new inputs_ready pulse until the handshake.
- NUM_IMAGES=3, CONTINUOUS=0, full run -> image_num 0,1,2; exactly 3 inputs_ready pulses; done=1, busy=0 at end. With CONTINUOUS=1 and enable high -> image_num wraps 2->0.
- abort asserted during RUN, then outputs_ready arrives -> IDLE, no label_valid; re-enable restarts at image_num=0. reset=0 asserted mid-ARGMAX -> all outputs at reset values in the same cycle.
- INFERENCE_ACCURACY_EN, NUM_IMAGES=4, expected labels matching 3 of 4 -> correct_count=3 at done.
